// File: rtl/full_sub.sv
// Ripple-borrow full subtractor (a - b - c) with a registered copy of the result,
// a capture-valid flag and a saturating count of captured borrows.
module full_sub #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             en,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic [WIDTH-1:0] d_r,
    output logic             borrow_r,
    output logic             valid_r,
    output logic [CNT_W-1:0] borrow_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH:0] bin;

    assign bin[0] = c;

    // One full-subtractor cell per bit; each cell's borrow-out feeds the next bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign d[i]     = a[i] ^ b[i] ^ bin[i];
        assign bin[i+1] = (~a[i] & b[i]) | (~a[i] & bin[i]) | (b[i] & bin[i]);
    end

    assign borrow = bin[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            d_r        <= '0;
            borrow_r   <= 1'b0;
            valid_r    <= 1'b0;
            borrow_cnt <= '0;
        end else if (en) begin
            d_r      <= d;
            borrow_r <= borrow;
            valid_r  <= 1'b1;
            // The counter sticks at all-ones rather than wrapping.
            if (borrow && (borrow_cnt != CNT_MAX)) begin
                borrow_cnt <= borrow_cnt + 1'b1;
            end
        end else begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_full_sub.sv
// Self-checking bench for full_sub: four instances of different widths checked every
// cycle against an arithmetic model, plus directed vectors with literal expectations.
module tb_full_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;

    // Instance index: 0 -> W1/C8, 1 -> W8/C2, 2 -> W4/C3, 3 -> W16/C8
    int wd[4] = '{1, 8, 4, 16};
    int cw[4] = '{8, 2, 3, 8};

    logic        a1, b1, c1, en1, rst1, d1, bo1, dr1, br1, v1;
    logic [7:0]  cnt1;
    logic [7:0]  a8, b8, d8, dr8;
    logic        c8, en8, rst8, bo8, br8, v8;
    logic [1:0]  cnt8;
    logic [3:0]  a4, b4, d4, dr4;
    logic        c4, en4, rst4, bo4, br4, v4;
    logic [2:0]  cnt4;
    logic [15:0] a16, b16, d16, dr16;
    logic        c16, en16, rst16, bo16, br16, v16;
    logic [7:0]  cnt16;

    full_sub #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .c(c1), .en(en1), .d(d1), .borrow(bo1),
        .d_r(dr1), .borrow_r(br1), .valid_r(v1), .borrow_cnt(cnt1));
    full_sub #(.WIDTH(8), .CNT_W(2)) u8 (
        .clk(clk), .rst(rst8), .a(a8), .b(b8), .c(c8), .en(en8), .d(d8), .borrow(bo8),
        .d_r(dr8), .borrow_r(br8), .valid_r(v8), .borrow_cnt(cnt8));
    full_sub #(.WIDTH(4), .CNT_W(3)) u4 (
        .clk(clk), .rst(rst4), .a(a4), .b(b4), .c(c4), .en(en4), .d(d4), .borrow(bo4),
        .d_r(dr4), .borrow_r(br4), .valid_r(v4), .borrow_cnt(cnt4));
    full_sub #(.WIDTH(16), .CNT_W(8)) u16 (
        .clk(clk), .rst(rst16), .a(a16), .b(b16), .c(c16), .en(en16), .d(d16), .borrow(bo16),
        .d_r(dr16), .borrow_r(br16), .valid_r(v16), .borrow_cnt(cnt16));

    logic [31:0] ia[4], ib[4], od[4], odr[4], ocnt[4];
    logic        ic[4], ien[4], irst[4], ob[4], obr[4], ov[4];

    always_comb begin
        ia[0] = 32'(a1);  ib[0] = 32'(b1);  ic[0] = c1;  ien[0] = en1;  irst[0] = rst1;
        ia[1] = 32'(a8);  ib[1] = 32'(b8);  ic[1] = c8;  ien[1] = en8;  irst[1] = rst8;
        ia[2] = 32'(a4);  ib[2] = 32'(b4);  ic[2] = c4;  ien[2] = en4;  irst[2] = rst4;
        ia[3] = 32'(a16); ib[3] = 32'(b16); ic[3] = c16; ien[3] = en16; irst[3] = rst16;
        od[0] = 32'(d1);  ob[0] = bo1;  odr[0] = 32'(dr1);  obr[0] = br1;  ov[0] = v1;  ocnt[0] = 32'(cnt1);
        od[1] = 32'(d8);  ob[1] = bo8;  odr[1] = 32'(dr8);  obr[1] = br8;  ov[1] = v8;  ocnt[1] = 32'(cnt8);
        od[2] = 32'(d4);  ob[2] = bo4;  odr[2] = 32'(dr4);  obr[2] = br4;  ov[2] = v4;  ocnt[2] = 32'(cnt4);
        od[3] = 32'(d16); ob[3] = bo16; odr[3] = 32'(dr16); obr[3] = br16; ov[3] = v16; ocnt[3] = 32'(cnt16);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int k, input longint a, input longint b,
                                 input bit c, input bit en, input bit rst);
        case (k)
            0: begin a1 = 1'(a);   b1 = 1'(b);   c1 = c;  en1 = en;  rst1 = rst;  end
            1: begin a8 = 8'(a);   b8 = 8'(b);   c8 = c;  en8 = en;  rst8 = rst;  end
            2: begin a4 = 4'(a);   b4 = 4'(b);   c4 = c;  en4 = en;  rst4 = rst;  end
            default: begin a16 = 16'(a); b16 = 16'(b); c16 = c; en16 = en; rst16 = rst; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed integer subtraction; a negative result means a borrow out.
    function automatic longint refDiff(input longint a, input longint b, input logic c);
        return a - b - longint'(c);
    endfunction

    function automatic longint maskOf(input int w);
        return (longint'(1) << w) - 1;
    endfunction

    longint m_dr[4], m_cnt[4];
    bit     m_br[4], m_v[4], m_ok[4];

    // Behavioural model of the registered outputs, one cycle behind the inputs.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            longint diff;
            diff = refDiff(longint'(ia[k]), longint'(ib[k]), ic[k]);
            if (irst[k]) begin
                m_dr[k] = 0; m_br[k] = 0; m_v[k] = 0; m_cnt[k] = 0; m_ok[k] = 1;
            end else if (ien[k]) begin
                m_dr[k] = diff & maskOf(wd[k]);
                m_br[k] = (diff < 0);
                m_v[k]  = 1;
                if (diff < 0 && m_cnt[k] < maskOf(cw[k])) m_cnt[k] = m_cnt[k] + 1;
            end else begin
                m_v[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 4; k++) begin
                longint diff;
                diff = refDiff(longint'(ia[k]), longint'(ib[k]), ic[k]);
                checkOutput($sformatf("u%0d.d", k), 64'(od[k]), 64'(diff & maskOf(wd[k])));
                checkOutput($sformatf("u%0d.borrow", k), 64'(ob[k]), 64'(diff < 0));
                if (m_ok[k]) begin
                    checkOutput($sformatf("u%0d.d_r", k), 64'(odr[k]), 64'(m_dr[k]));
                    checkOutput($sformatf("u%0d.borrow_r", k), 64'(obr[k]), 64'(m_br[k]));
                    checkOutput($sformatf("u%0d.valid_r", k), 64'(ov[k]), 64'(m_v[k]));
                    checkOutput($sformatf("u%0d.borrow_cnt", k), 64'(ocnt[k]), 64'(m_cnt[k]));
                end
            end
        end
    end

    logic [7:0] tt_d   = 8'b1001_0110;
    logic [7:0] tt_b   = 8'b1000_1110;
    int         sat[5] = '{1, 2, 3, 3, 3};

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_ok[k] = 0; m_dr[k] = 0; m_cnt[k] = 0; m_br[k] = 0; m_v[k] = 0;
            applyStimulus(k, 0, 0, 0, 0, 1);
        end
        run = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 4; k++) applyStimulus(k, 0, 0, 0, 0, 0);
        tick();

        // 1-bit truth table, 5-unit step.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] abc;
            abc = 3'(v);
            applyStimulus(0, abc[2], abc[1], abc[0], 0, 0);
            #1;
            checkOutput($sformatf("tt%0d.d", v), 64'(d1), 64'(tt_d[v]));
            checkOutput($sformatf("tt%0d.borrow", v), 64'(bo1), 64'(tt_b[v]));
            #4;
        end
        tick();

        // Reset held two cycles while the combinational path tracks 001.
        applyStimulus(0, 0, 0, 1, 0, 1);
        tick();
        tick();
        checkOutput("rst.d", 64'(d1), 64'd1);
        checkOutput("rst.borrow", 64'(bo1), 64'd1);
        checkOutput("rst.d_r", 64'(dr1), 64'd0);
        checkOutput("rst.borrow_r", 64'(br1), 64'd0);
        checkOutput("rst.valid_r", 64'(v1), 64'd0);
        checkOutput("rst.cnt", 64'(cnt1), 64'd0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        tick();

        // Single capture of 010, then hold.
        applyStimulus(0, 0, 1, 0, 1, 0);
        tick();
        checkOutput("cap.d_r", 64'(dr1), 64'd1);
        checkOutput("cap.borrow_r", 64'(br1), 64'd1);
        checkOutput("cap.valid_r", 64'(v1), 64'd1);
        checkOutput("cap.cnt", 64'(cnt1), 64'd1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        tick();
        checkOutput("hold.valid_r", 64'(v1), 64'd0);
        checkOutput("hold.d_r", 64'(dr1), 64'd1);
        checkOutput("hold.borrow_r", 64'(br1), 64'd1);
        checkOutput("hold.cnt", 64'(cnt1), 64'd1);

        // 8-bit directed and boundary vectors.
        applyStimulus(1, 'h05, 'h03, 1, 0, 0); #1;
        checkOutput("w8a.d", 64'(d8), 64'h01);
        checkOutput("w8a.borrow", 64'(bo8), 64'd0);
        applyStimulus(1, 'h00, 'hFF, 1, 0, 0); #1;
        checkOutput("w8b.d", 64'(d8), 64'h00);
        checkOutput("w8b.borrow", 64'(bo8), 64'd1);
        applyStimulus(1, 'h80, 'h80, 1, 0, 0); #1;
        checkOutput("w8c.d", 64'(d8), 64'hFF);
        checkOutput("w8c.borrow", 64'(bo8), 64'd1);
        applyStimulus(1, 'hFF, 'h00, 0, 0, 0); #1;
        checkOutput("w8d.d", 64'(d8), 64'hFF);
        checkOutput("w8d.borrow", 64'(bo8), 64'd0);
        tick();

        // 2-bit counter saturation, then reset overriding en.
        applyStimulus(1, 0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("sat%0d.cnt", i), 64'(cnt8), 64'(sat[i]));
            checkOutput($sformatf("sat%0d.valid_r", i), 64'(v8), 64'd1);
        end
        applyStimulus(1, 0, 1, 0, 1, 1);
        tick();
        checkOutput("rsten.d_r", 64'(dr8), 64'd0);
        checkOutput("rsten.borrow_r", 64'(br8), 64'd0);
        checkOutput("rsten.valid_r", 64'(v8), 64'd0);
        checkOutput("rsten.cnt", 64'(cnt8), 64'd0);
        checkOutput("rsten.borrow", 64'(bo8), 64'd1);
        applyStimulus(1, 0, 0, 0, 0, 0);

        // Random vectors on the 4- and 16-bit instances.
        for (int n = 0; n < 1000; n++) begin
            for (int k = 2; k < 4; k++) begin
                applyStimulus(k, longint'($urandom) & maskOf(wd[k]),
                              longint'($urandom) & maskOf(wd[k]),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 31) == 0));
            end
            tick();
        end

        tick();
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/full_sub.md
Name: full_sub

Overview:
- Parameterised ripple-borrow full subtractor computing a - b - c, where c is the borrow-in.
- Combinational difference and borrow outputs, plus a registered copy with a valid flag and a saturating borrow-event counter.
- Default WIDTH=1 gives the classic 1-bit full subtractor cell used by arithmetic datapaths and for gate-level checks.
- One clock domain; reset is synchronous and active-high.

Parameters:
- WIDTH, 1, operand and difference width in bits (legal range 1..32).
- CNT_W, 8, width of the saturating borrow-event counter.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- c  input  1  borrow-in.
- en  input  1  capture strobe for the registered outputs and counter.
- d  output  WIDTH  combinational difference, (a - b - c) mod 2^WIDTH.
- borrow  output  1  combinational borrow-out; 1 when a < b + c, treated as unsigned.
- d_r  output  WIDTH  registered difference.
- borrow_r  output  1  registered borrow-out.
- valid_r  output  1  high for the cycle after a capture.
- borrow_cnt  output  CNT_W  saturating count of captured borrows.

Behaviour:
- Combinational path, zero latency, independent of clk, rst and en:
  - {borrow, d} = {1'b0, a} - {1'b0, b} - c, computed in WIDTH+1 bits.
  - Implement as a ripple chain of 1-bit cells. For each bit i: d[i] = a[i]^b[i]^bin_i, and bout_i = (~a[i]&b[i]) | (~a[i]&bin_i) | (b[i]&bin_i).
  - bin_0 = c, bin_{i+1} = bout_i, and borrow = bout_{WIDTH-1}.
- 1-bit truth table, listed as abc -> d borrow:
  - 000 -> 0 0
  - 001 -> 1 1
  - 010 -> 1 1
  - 011 -> 0 1
  - 100 -> 1 0
  - 101 -> 0 0
  - 110 -> 0 0
  - 111 -> 1 1
- Inputs containing X or Z drive X on the affected outputs; no special handling is required.
- Registered path, 1-cycle latency:
  - rst=1 at a rising edge: d_r=0, borrow_r=0, valid_r=0, borrow_cnt=0.
  - rst overrides en on the same edge.
  - rst=0 and en=1: d_r<=d, borrow_r<=borrow, valid_r<=1.
  - In the same case, if borrow=1 and borrow_cnt is below its maximum (2^CNT_W - 1), borrow_cnt increments by 1.
  - rst=0 and en=0: d_r and borrow_r hold, valid_r<=0, borrow_cnt holds.
- Counter:
  - Saturates at all-ones and never wraps.
  - Only rst clears it.
- Reset asserted mid-stream: the registered outputs clear on that edge. The combinational d/borrow are unaffected.
- Back-to-back en=1: every cycle captures, and valid_r stays high.
- Boundary cases:
  - a=0, b=all-ones, c=1: d=0, borrow=1.
  - a=all-ones, b=0, c=0: d=all-ones, borrow=0.
  - a=b, c=1: d=all-ones, borrow=1.
- No latches and no internal state other than d_r, borrow_r, valid_r and borrow_cnt.

Test Plan:
- WIDTH=1: sweep abc 000..111 with a 5-time-unit step and check d/borrow against the truth table each step, e.g. 011 -> d=0, borrow=1 and 100 -> d=1, borrow=0.
- WIDTH=1: hold rst=1 for 2 cycles, then release. d_r=0, borrow_r=0, valid_r=0 and borrow_cnt=0, while d/borrow still track the inputs (001 -> 1,1).
- WIDTH=1: apply en=1 with abc=010 for one cycle, then en=0. Next cycle d_r=1, borrow_r=1, valid_r=1 and borrow_cnt=1. The cycle after, valid_r=0 and the values hold.
- WIDTH=8: a=0x05, b=0x03, c=1 -> d=0x01, borrow=0. Then a=0x00, b=0xFF, c=1 -> d=0x00, borrow=1. Then a=0x80, b=0x80, c=1 -> d=0xFF, borrow=1.
- CNT_W=2: hold en=1 with a=0, b=1, c=0 (borrow=1) for 5 cycles -> borrow_cnt goes 1, 2, 3, 3, 3. Then assert rst with en=1 -> all registers read 0 next cycle.
- Random: 1000 vectors at WIDTH=4 and WIDTH=16 with random en/rst. Check the combinational outputs against the reference expression, and the registered outputs against a 1-cycle-delayed model including saturation.
